ip_tx_framer: RTL and testbench
===============================

// Module: ip_tx_framer
// PURPOSE
//  Streaming IPv4 transmit framer. Per datagram request: computes header checksum
//  sequentially, emits the 20-byte header, then passes the payload stream through.
//  Sits between the UDP packer (upstream) and the MAC framer (downstream).
//  Extends our fixed combinational header builder: parametrised bus width, auto ID, length check.
// PARAMETERS
//  DATA_BYTES  1      bytes per beat; legal 1,2,4 (20 % DATA_BYTES == 0)
//  IP_TTL      8'd64  time-to-live field
//  IP_PROTO    8'd17  protocol field (UDP)
//  IP_DF       1'b1   don't-fragment flag; MF=0, frag offset=0, TOS=0, IHL=5
// PORTS
//  clk          in   1        single clock
//  rst          in   1        reset: asynchronous, active-high
//  src_ip       in   32       source address, sampled on request accept
//  dst_ip       in   32       destination address, sampled on request accept
//  req_len      in   16       payload length in bytes
//  req_valid    in   1        datagram request
//  req_ready    out  1        request accepted when req_valid & req_ready
//  s_tdata      in   8*DB     payload in, first byte in MSB lane
//  s_tkeep      in   DB       byte enables, contiguous from MSB, partial only on s_tlast
//  s_tvalid/s_tlast in 1 each; s_tready out 1
//  m_tdata      out  8*DB     datagram out, network byte order, first byte MSB lane
//  m_tkeep      out  DB       all ones on header beats, s_tkeep on payload
//  m_tvalid/m_tlast out 1 each; m_tready in 1
//  ip_id        out  16       ID used for the current/next datagram
//  busy         out  1        high in any state but IDLE
//  err_len      out  1        one-cycle pulse on length fault
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0,
//   m_tkeep=0, ip_id=0, busy=0, err_len=0; reset mid-frame aborts; no partial output resumes.
//  FSM: IDLE -> CSUM -> FOLD -> HDR -> PAY -> IDLE.
//  IDLE: req_ready=1; on accept latch src/dst/len, tot_len=req_len+20.
//   req_len>65515: pulse err_len next cycle, stay IDLE, no output.
//  CSUM: 10 cycles; 20-bit acc sums the 10 header 16-bit words, checksum word = 0.
//  FOLD: 1 cycle; s1=acc[15:0]+acc[19:16]; s2=s1[15:0]+s1[16]; csum=~s2 (two folds, mandatory).
//  Latency: accept in cycle T -> first header beat m_tvalid in T+12.
//  HDR: 20/DB beats; advance only on m_valid&m_ready; m_tdata held stable while stalled.
//   req_len==0: m_tlast on final header beat, -> IDLE.
//  PAY: s_tready = m_tready (combinational pass, zero added latency); data/keep/last forwarded.
//   Byte counter adds popcount(s_tkeep) per beat. Frame ends on s_tlast regardless of req_len.
//   At s_tlast, count != req_len -> err_len pulse the cycle after; frame still closed normally.
//  ip_id increments (mod 2^16, wraps 0xFFFF->0) when the final beat is accepted; not on rejected requests.
//  s_tready=0 outside PAY; req_ready=0 outside IDLE.
// STRUCTURE
//  ip_pkg: header constants (version 4, IHL 5, min/max length), state enum, field offsets.
//  Sub-module ip_csum_acc: 16-bit word accumulator + double fold + invert; clear/add/done ports.
//  Header held as 160-bit register, shifted out DATA_BYTES per beat.
// TESTING
//  1 DB=1, src C0A8010A, dst C0A80101, len 8, id 0 -> header
//    45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01, then 8 payload bytes, tlast on byte 28.
//  2 Same request x2 -> second header id 0x0001, checksum 0xB774; ip_id preload 0xFFFF -> wraps to 0.
//  3 DB=4, len 5, last keep 4'b1000 -> 5 header beats + 2 payload beats, m_tkeep 1111 then 1000.
//  4 Random m_tready stalls during HDR/PAY -> byte stream identical to unstalled run, no drop/dup.
//  5 len 8 but s_tlast after 6 bytes -> frame closes at byte 26, err_len one pulse; len 65516 -> rejected.
//  6 rst asserted mid-PAY -> m_tvalid 0 immediately, busy 0, next request framed correctly, id 0.

Source files
------------

// File: rtl/ip_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ip_tx_framer_pkg
// Description : IPv4 header constants, FSM state encodings, header field
//               offsets and the 160-bit header builder for ip_tx_framer.
// Revision    : 1.0 - initial release
// ============================================================================
package ip_tx_framer_pkg;

  localparam logic [3:0]  IP_VERSION     = 4'd4;
  localparam logic [3:0]  IP_IHL         = 4'd5;
  localparam int          HDR_BYTES      = 20;
  localparam int          HDR_WORDS      = 10;
  localparam logic [15:0] IP_HDR_LEN     = 16'd20;
  localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

  // Bit offset of the LSB of the checksum field inside the 160-bit header
  localparam int          CSUM_LSB       = 64;

  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_CSUM = 3'd1;
  localparam logic [2:0]  ST_FOLD = 3'd2;
  localparam logic [2:0]  ST_HDR  = 3'd3;
  localparam logic [2:0]  ST_PAY  = 3'd4;

  // Header in network order, first byte at bit 159; TOS, MF and offset are 0
  function automatic logic [159:0] build_hdr(
    input logic [15:0] tot_len,
    input logic [15:0] id,
    input logic        df,
    input logic [7:0]  ttl,
    input logic [7:0]  proto,
    input logic [15:0] csum,
    input logic [31:0] src,
    input logic [31:0] dst
  );
    return {IP_VERSION, IP_IHL, 8'h00, tot_len, id,
            1'b0, df, 1'b0, 13'd0, ttl, proto, csum, src, dst};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_tx_framer_csum_acc.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_framer_csum_acc
// Description : Sequential 16-bit one's-complement word accumulator with a
//               20-bit sum, double end-around fold and final inversion.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_framer_csum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  input  logic        done_i,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Accumulate one header word per add cycle; clear starts a new datagram
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_q + {4'd0, word_i};
    end
  end

  // Two folds are needed: the first one can itself carry out of bit 15
  always_comb begin
    fold1  = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    fold2  = fold1[15:0] + {15'd0, fold1[16]};
    csum_o = done_i ? ~fold2 : 16'h0000;
  end

endmodule
`default_nettype wire

// File: rtl/ip_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_framer
// Description : Streaming IPv4 transmit framer. Computes the header checksum
//               over 10 cycles, emits the 20-byte header DATA_BYTES per beat,
//               then passes the payload stream through combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_framer
  import ip_tx_framer_pkg::*;
#(
  parameter int         DATA_BYTES = 1,
  parameter logic [7:0] IP_TTL     = 8'd64,
  parameter logic [7:0] IP_PROTO   = 8'd17,
  parameter logic       IP_DF      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             src_ip_i,
  input  logic [31:0]             dst_ip_i,
  input  logic [15:0]             req_len_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [8*DATA_BYTES-1:0] s_tdata_i,
  input  logic [DATA_BYTES-1:0]   s_tkeep_i,
  input  logic                    s_tvalid_i,
  input  logic                    s_tlast_i,
  output logic                    s_tready_o,
  output logic [8*DATA_BYTES-1:0] m_tdata_o,
  output logic [DATA_BYTES-1:0]   m_tkeep_o,
  output logic                    m_tvalid_o,
  output logic                    m_tlast_o,
  input  logic                    m_tready_i,
  output logic [15:0]             ip_id_o,
  output logic                    busy_o,
  output logic                    err_len_o
);

  localparam int         DW        = 8 * DATA_BYTES;
  localparam int         HDR_BEATS = HDR_BYTES / DATA_BYTES;
  localparam logic [4:0] HDR_LAST  = 5'(HDR_BEATS - 1);
  localparam logic [4:0] CSUM_LAST = 5'(HDR_WORDS - 1);

  logic [2:0]   state_q, state_d;
  logic [159:0] hdr_q,   hdr_d;
  logic [4:0]   cnt_q,   cnt_d;
  logic [15:0]  len_q,   len_d;
  logic [16:0]  bytes_q, bytes_d;
  logic [15:0]  id_q,    id_d;
  logic         err_q,   err_d;

  logic         csum_clear, csum_add, csum_done;
  logic [15:0]  csum;
  logic [2:0]   keep_cnt;

  ip_tx_framer_csum_acc u_csum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (csum_clear),
    .add_i   (csum_add),
    .word_i  (hdr_q[159:144]),
    .done_i  (csum_done),
    .csum_o  (csum)
  );

  // Number of valid bytes in the current payload beat
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_cnt = keep_cnt + {2'b00, s_tkeep_i[i]};
    end
  end

  // Output mux: header register while in HDR, straight payload pass in PAY
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    s_tready_o  = (state_q == ST_PAY) & m_tready_i;
    m_tvalid_o  = 1'b0;
    m_tlast_o   = 1'b0;
    m_tdata_o   = '0;
    m_tkeep_o   = '0;
    case (state_q)
      ST_HDR: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = hdr_q[159 -: DW];
        m_tkeep_o  = '1;
        m_tlast_o  = (cnt_q == HDR_LAST) && (len_q == 16'd0);
      end
      ST_PAY: begin
        m_tvalid_o = s_tvalid_i;
        m_tdata_o  = s_tdata_i;
        m_tkeep_o  = s_tkeep_i;
        m_tlast_o  = s_tlast_i;
      end
      default: ;
    endcase
  end

  // Next-state logic; the header register rotates during CSUM so the
  // accumulator always sees the next word at the top, ending where it began
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    bytes_d    = bytes_q;
    id_d       = id_q;
    err_d      = 1'b0;
    csum_clear = 1'b0;
    csum_add   = 1'b0;
    csum_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_len_i > IP_MAX_PAYLOAD) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_CSUM;
            len_d      = req_len_i;
            cnt_d      = '0;
            bytes_d    = '0;
            csum_clear = 1'b1;
            hdr_d      = build_hdr(req_len_i + IP_HDR_LEN, id_q, IP_DF, IP_TTL,
                                   IP_PROTO, 16'h0000, src_ip_i, dst_ip_i);
          end
        end
      end
      ST_CSUM: begin
        csum_add = 1'b1;
        hdr_d    = {hdr_q[143:0], hdr_q[159:144]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CSUM_LAST) begin
          state_d = ST_FOLD;
          cnt_d   = '0;
        end
      end
      ST_FOLD: begin
        csum_done              = 1'b1;
        hdr_d[CSUM_LSB +: 16]  = csum;
        state_d                = ST_HDR;
      end
      ST_HDR: begin
        if (m_tready_i) begin
          hdr_d = hdr_q << DW;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (len_q == 16'd0) begin
              state_d = ST_IDLE;
              id_d    = id_q + 16'd1;
            end else begin
              state_d = ST_PAY;
            end
          end
        end
      end
      ST_PAY: begin
        if (s_tvalid_i && m_tready_i) begin
          bytes_d = bytes_q + {14'd0, keep_cnt};
          if (s_tlast_i) begin
            state_d = ST_IDLE;
            id_d    = id_q + 16'd1;
            err_d   = (bytes_d != {1'b0, len_q});
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      bytes_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bytes_q <= bytes_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign ip_id_o   = id_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign err_len_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ip_tx_framer
// Description : Directed self-checking bench for ip_tx_framer (DB=1 and DB=4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DATA_BYTES = 1 instance
  logic [31:0] src_ip, dst_ip;
  logic [15:0] req_len;
  logic        req_valid, req_ready;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] ip_id;
  logic        busy, err_len;

  // DATA_BYTES = 4 instance
  logic [31:0] src_ip4, dst_ip4;
  logic [15:0] req_len4;
  logic        req_valid4, req_ready4;
  logic [31:0] s_tdata4;
  logic [3:0]  s_tkeep4;
  logic        s_tvalid4, s_tlast4, s_tready4;
  logic [31:0] m_tdata4;
  logic [3:0]  m_tkeep4;
  logic        m_tvalid4, m_tlast4, m_tready4;
  logic [15:0] ip_id4;
  logic        busy4, err_len4;

  ip_tx_framer #(.DATA_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .src_ip_i(src_ip), .dst_ip_i(dst_ip), .req_len_i(req_len),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .s_tdata_i(s_tdata),
    .s_tkeep_i(s_tkeep), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast),
    .m_tready_i(m_tready), .ip_id_o(ip_id), .busy_o(busy), .err_len_o(err_len)
  );

  ip_tx_framer #(.DATA_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .src_ip_i(src_ip4), .dst_ip_i(dst_ip4), .req_len_i(req_len4),
    .req_valid_i(req_valid4), .req_ready_o(req_ready4), .s_tdata_i(s_tdata4),
    .s_tkeep_i(s_tkeep4), .s_tvalid_i(s_tvalid4), .s_tlast_i(s_tlast4), .s_tready_o(s_tready4),
    .m_tdata_o(m_tdata4), .m_tkeep_o(m_tkeep4), .m_tvalid_o(m_tvalid4), .m_tlast_o(m_tlast4),
    .m_tready_i(m_tready4), .ip_id_o(ip_id4), .busy_o(busy4), .err_len_o(err_len4)
  );

  int  n_checks = 0;
  int  n_fail   = 0;

  bq_t cap_q;
  int  cap_last;
  int  err_pulses;
  int  first_valid;
  int  keep_bad;
  int  extra_valid;
  bit  timeout;
  int  pay_seed;

  function automatic logic [7:0] pay_byte(input int i);
    return 8'((i * 37 + pay_seed * 11 + 5) & 255);
  endfunction

  // Reference header: plain sum of ten words with repeated end-around carry
  function automatic logic [159:0] exp_hdr(input logic [31:0] s, input logic [31:0] d,
                                           input logic [15:0] len, input logic [15:0] id);
    logic [159:0] h;
    logic [31:0]  sum;
    h   = {8'h45, 8'h00, len + 16'd20, id, 16'h4000, 8'h40, 8'h11, 16'h0000, s, d};
    sum = 32'd0;
    for (int k = 0; k < 10; k++) sum = sum + {16'd0, h[159 - 16*k -: 16]};
    while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    h[79:64] = ~sum[15:0];
    return h;
  endfunction

  function automatic bq_t exp_stream(input logic [159:0] h, input int npay);
    bq_t q;
    for (int k = 0; k < 20; k++) q.push_back(h[159 - 8*k -: 8]);
    for (int k = 0; k < npay; k++) q.push_back(pay_byte(k));
    return q;
  endfunction

  // Index of the first differing byte, or -1 when both streams are identical
  function automatic int first_diff(input bq_t got, input bq_t exp);
    int n;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int k = 0; k < n; k++) if (got[k] !== exp[k]) return k;
    if (got.size() != exp.size()) return n;
    return -1;
  endfunction

  // Issue one request on the DB=1 instance and capture the output frame
  task automatic frame_run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                           input int npay, input int stall_pct, input int budget);
    int idx, cyc;
    bit done;
    cap_q.delete();
    cap_last = -1; err_pulses = 0; first_valid = -1; keep_bad = 0; extra_valid = 0;
    idx = 0; cyc = 0; done = 0;
    @(negedge clk);
    src_ip = s; dst_ip = d; req_len = len; req_valid = 1'b1;
    while (!done && cyc < budget) begin
      m_tready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      s_tvalid = (idx < npay);
      s_tdata  = pay_byte(idx);
      s_tkeep  = 1'b1;
      s_tlast  = (idx == npay - 1);
      #1;
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (err_len) err_pulses++;
      if (m_tvalid && m_tready) begin
        cap_q.push_back(m_tdata);
        if (m_tkeep !== 1'b1) keep_bad++;
        if (m_tlast) begin
          cap_last = cap_q.size();
          done = 1;
        end
      end
      if (s_tvalid && s_tready) idx++;
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
    end
    timeout  = !done;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (err_len) err_pulses++;
      if (m_tvalid) extra_valid++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, s_tready, m_tvalid, m_tlast, busy, err_len} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {req_ready, s_tready, m_tvalid, m_tlast, busy, err_len});
    end
    n_checks++;
    if ({m_tdata, m_tkeep, ip_id} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {m_tdata, m_tkeep, ip_id});
    end
    n_checks++;
    if ({req_ready4, s_tready4, m_tvalid4, m_tlast4, busy4, err_len4, m_tdata4, m_tkeep4, ip_id4}
        !== {6'b100000, 52'd0}) begin
      n_fail++;
      $display("FAIL reset_db4: got %h expected %h",
               {req_ready4, s_tready4, m_tvalid4, m_tlast4, busy4, err_len4, m_tdata4, m_tkeep4, ip_id4},
               {6'b100000, 52'd0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [159:0] ref_h;
    int diff;
    ref_h = 160'h4500_001C_0000_4000_4011_B775_C0A8_010A_C0A8_0101;
    pay_seed = 0;
    frame_run(32'hC0A8010A, 32'hC0A80101, 16'd8, 8, 0, 200);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
    n_checks++;
    if (first_valid !== 12) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 12", first_valid);
    end
    diff = first_diff(cap_q, exp_stream(ref_h, 8));
    n_checks++;
    if (diff !== -1) begin
      n_fail++; $display("FAIL basic_stream: first bad byte %0d got %h", diff, diff < cap_q.size() ? cap_q[diff] : 8'hxx);
    end
    n_checks++;
    if (cap_last !== 28) begin n_fail++; $display("FAIL basic_tlast: got %0d expected 28", cap_last); end
    n_checks++;
    if ({err_pulses, keep_bad, extra_valid} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL basic_misc: err %0d keep %0d extra %0d expected 0 0 0", err_pulses, keep_bad, extra_valid);
    end
    n_checks++;
    if (ip_id !== 16'h0001) begin n_fail++; $display("FAIL basic_id: got %h expected 0001", ip_id); end
  endtask

  task automatic test_back_to_back();
    logic [159:0] ref_h;
    int diff;
    ref_h = 160'h4500_001C_0001_4000_4011_B774_C0A8_010A_C0A8_0101;
    pay_seed = 1;
    frame_run(32'hC0A8010A, 32'hC0A80101, 16'd8, 8, 0, 200);
    diff = first_diff(cap_q, exp_stream(ref_h, 8));
    n_checks++;
    if (diff !== -1 || timeout) begin
      n_fail++; $display("FAIL b2b_stream: first bad byte %0d timeout %0d expected -1 0", diff, timeout);
    end
    n_checks++;
    if (ip_id !== 16'h0002) begin n_fail++; $display("FAIL b2b_id: got %h expected 0002", ip_id); end
  endtask

  task automatic test_stall();
    int diff;
    pay_seed = 9;
    frame_run(32'h0A000001, 32'h0A0000FE, 16'd13, 13, 40, 2000);
    diff = first_diff(cap_q, exp_stream(exp_hdr(32'h0A000001, 32'h0A0000FE, 16'd13, 16'h0002), 13));
    n_checks++;
    if (diff !== -1 || timeout) begin
      n_fail++; $display("FAIL stall_stream: first bad byte %0d timeout %0d expected -1 0", diff, timeout);
    end
    n_checks++;
    if (cap_last !== 33 || extra_valid !== 0) begin
      n_fail++; $display("FAIL stall_tlast: got %0d extra %0d expected 33 0", cap_last, extra_valid);
    end
  endtask

  task automatic test_len_err();
    int diff;
    pay_seed = 3;
    frame_run(32'hC0A8010A, 32'hC0A80101, 16'd8, 6, 0, 200);
    diff = first_diff(cap_q, exp_stream(exp_hdr(32'hC0A8010A, 32'hC0A80101, 16'd8, 16'h0003), 6));
    n_checks++;
    if (diff !== -1 || timeout) begin
      n_fail++; $display("FAIL lenerr_stream: first bad byte %0d timeout %0d expected -1 0", diff, timeout);
    end
    n_checks++;
    if (cap_last !== 26) begin n_fail++; $display("FAIL lenerr_tlast: got %0d expected 26", cap_last); end
    n_checks++;
    if (err_pulses !== 1) begin n_fail++; $display("FAIL lenerr_pulse: got %0d expected 1", err_pulses); end
    n_checks++;
    if (ip_id !== 16'h0004) begin n_fail++; $display("FAIL lenerr_id: got %h expected 0004", ip_id); end
  endtask

  task automatic test_reject();
    int errs, mv, bz;
    errs = 0; mv = 0; bz = 0;
    @(negedge clk);
    src_ip = 32'h01020304; dst_ip = 32'h05060708; req_len = 16'd65516; req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (err_len) errs++;
      if (m_tvalid) mv++;
      if (c > 0 && busy) bz++;
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_checks++;
    if (errs !== 1) begin n_fail++; $display("FAIL reject_pulse: got %0d expected 1", errs); end
    n_checks++;
    if (mv !== 0 || bz !== 0) begin
      n_fail++; $display("FAIL reject_quiet: valid %0d busy %0d expected 0 0", mv, bz);
    end
    n_checks++;
    if (ip_id !== 16'h0004) begin n_fail++; $display("FAIL reject_id: got %h expected 0004", ip_id); end
  endtask

  task automatic test_reset_mid();
    logic [159:0] h;
    bq_t got;
    int pidx, diff;
    h = exp_hdr(32'hAC100001, 32'hAC100002, 16'd65515, 16'h0004);
    pay_seed = 4; pidx = 0;
    @(negedge clk);
    src_ip = 32'hAC100001; dst_ip = 32'hAC100002; req_len = 16'd65515; req_valid = 1'b1;
    m_tready = 1'b1;
    for (int c = 0; c < 80 && got.size() < 23; c++) begin
      s_tvalid = 1'b1; s_tdata = pay_byte(pidx); s_tkeep = 1'b1; s_tlast = 1'b0;
      #1;
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      if (s_tvalid && s_tready) pidx++;
      @(negedge clk);
      req_valid = 1'b0;
    end
    diff = first_diff(got, exp_stream(h, 3));
    n_checks++;
    if (diff !== -1) begin n_fail++; $display("FAIL maxlen_hdr: first bad byte %0d expected -1", diff); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_tvalid, busy, s_tready, req_ready, ip_id} !== {4'b0001, 16'h0000}) begin
      n_fail++; $display("FAIL midrst_state: got %h expected %h",
                         {m_tvalid, busy, s_tready, req_ready, ip_id}, {4'b0001, 16'h0000});
    end
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0;
    pay_seed = 5;
    frame_run(32'hC0A8010A, 32'hC0A80101, 16'd8, 8, 0, 200);
    diff = first_diff(cap_q, exp_stream(exp_hdr(32'hC0A8010A, 32'hC0A80101, 16'd8, 16'h0000), 8));
    n_checks++;
    if (diff !== -1 || timeout || cap_last !== 28) begin
      n_fail++; $display("FAIL midrst_frame: first bad byte %0d last %0d expected -1 28", diff, cap_last);
    end
  endtask

  task automatic test_wrap();
    int diff;
    @(negedge clk);
    force dut1.id_q = 16'hFFFF;
    @(negedge clk);
    release dut1.id_q;
    #1;
    n_checks++;
    if (ip_id !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", ip_id); end
    frame_run(32'hC0A8010A, 32'hC0A80101, 16'd0, 0, 0, 200);
    diff = first_diff(cap_q, exp_stream(exp_hdr(32'hC0A8010A, 32'hC0A80101, 16'd0, 16'hFFFF), 0));
    n_checks++;
    if (diff !== -1 || timeout || cap_last !== 20) begin
      n_fail++; $display("FAIL wrap_frame: first bad byte %0d last %0d expected -1 20", diff, cap_last);
    end
    n_checks++;
    if (ip_id !== 16'h0000) begin n_fail++; $display("FAIL wrap_id: got %h expected 0000", ip_id); end
  endtask

  task automatic test_db4();
    logic [159:0] h;
    logic [31:0]  bd[$];
    logic [3:0]   bk[$];
    logic         bl[$];
    logic [27:0]  keeps;
    logic [6:0]   lasts;
    int pidx, errs, hbad;
    bit got_last;
    h = exp_hdr(32'hC0A8010A, 32'hC0A80101, 16'd5, 16'h0000);
    pidx = 0; errs = 0; hbad = 0; got_last = 0;
    @(negedge clk);
    src_ip4 = 32'hC0A8010A; dst_ip4 = 32'hC0A80101; req_len4 = 16'd5; req_valid4 = 1'b1;
    m_tready4 = 1'b1;
    for (int c = 0; c < 60 && !got_last; c++) begin
      s_tvalid4 = (pidx < 2);
      s_tdata4  = (pidx == 0) ? 32'hAABBCCDD : 32'hEE000000;
      s_tkeep4  = (pidx == 0) ? 4'b1111 : 4'b1000;
      s_tlast4  = (pidx == 1);
      #1;
      if (err_len4) errs++;
      if (m_tvalid4 && m_tready4) begin
        bd.push_back(m_tdata4); bk.push_back(m_tkeep4); bl.push_back(m_tlast4);
        if (m_tlast4) got_last = 1;
      end
      if (s_tvalid4 && s_tready4) pidx++;
      @(negedge clk);
      req_valid4 = 1'b0;
    end
    s_tvalid4 = 1'b0; s_tlast4 = 1'b0;
    repeat (3) begin #1; if (err_len4) errs++; @(negedge clk); end
    n_checks++;
    if (bd.size() !== 7) begin
      n_fail++; $display("FAIL db4_beats: got %0d expected 7", bd.size());
    end else begin
      for (int b = 0; b < 5; b++) if (bd[b] !== h[159 - 32*b -: 32]) hbad++;
      keeps = '0; lasts = '0;
      for (int b = 0; b < 7; b++) begin
        keeps = {keeps[23:0], bk[b]};
        lasts = {lasts[5:0], bl[b]};
      end
      n_checks++;
      if (hbad !== 0) begin n_fail++; $display("FAIL db4_hdr: got %0d bad beats expected 0", hbad); end
      n_checks++;
      if (keeps !== 28'hFFFFFF8) begin n_fail++; $display("FAIL db4_keep: got %h expected ffffff8", keeps); end
      n_checks++;
      if (lasts !== 7'b0000001) begin n_fail++; $display("FAIL db4_last: got %b expected 0000001", lasts); end
      n_checks++;
      if (bd[5] !== 32'hAABBCCDD || bd[6][31:24] !== 8'hEE) begin
        n_fail++; $display("FAIL db4_pay: got %h %h expected aabbccdd ee......", bd[5], bd[6]);
      end
    end
    n_checks++;
    if (errs !== 0 || ip_id4 !== 16'h0001) begin
      n_fail++; $display("FAIL db4_end: err %0d id %h expected 0 0001", errs, ip_id4);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_ip = '0; dst_ip = '0; req_len = '0; req_valid = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    src_ip4 = '0; dst_ip4 = '0; req_len4 = '0; req_valid4 = 1'b0;
    s_tdata4 = '0; s_tkeep4 = '0; s_tvalid4 = 1'b0; s_tlast4 = 1'b0; m_tready4 = 1'b1;
    pay_seed = 0; timeout = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_len_err();
    test_reject();
    test_reset_mid();
    test_wrap();
    test_db4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
